// File: rtl/des_out_fifo.sv
// Output buffer behind the pipelined DES core: captures every 64-bit result
// and streams each one out as two 32-bit words (high half first) over valid/ready.
module des_out_fifo #(
    parameter int DEPTH        = 16,
    parameter int AFULL_MARGIN = 17,
    parameter int CW           = $clog2(DEPTH) + 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [63:0]   i_ciphertext,
    input  logic          i_dv,
    output logic [31:0]   o_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [CW-1:0] o_count,
    output logic          o_almost_full,
    output logic          o_overflow,
    input  logic          i_clr_overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          half;
    logic          overflow;
    logic          xfer, pop_now, full, push;
    logic [63:0]   head;
    logic [31:0]   free_cnt;

    assign xfer    = o_valid && i_ready;
    assign pop_now = xfer && half;
    assign full    = (count == CW'(DEPTH));
    // A full FIFO still accepts a push when the head's low word leaves this cycle.
    assign push    = i_dv && (!full || pop_now);

    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= i_ciphertext;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            half     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push)    wr_ptr <= wr_ptr + 1'b1;
            if (pop_now) rd_ptr <= rd_ptr + 1'b1;
            if (xfer)    half   <= ~half;
            case ({push, pop_now})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Dropping data outranks a same-cycle clear.
            if (i_dv && !push)       overflow <= 1'b1;
            else if (i_clr_overflow) overflow <= 1'b0;
        end
    end

    assign head          = mem[rd_ptr];
    assign o_valid       = (count != '0);
    assign o_data        = !o_valid ? 32'h0 : (half ? head[31:0] : head[63:32]);
    assign o_count       = count;
    assign o_overflow    = overflow;
    assign free_cnt      = 32'(DEPTH) - 32'(count);
    assign o_almost_full = (free_cnt <= 32'(AFULL_MARGIN));

endmodule

// File: tb/tb_des_out_fifo.sv
// Directed bench for des_out_fifo: stimulus queues expected words, a negedge
// monitor pops and compares every word the DUT hands over.
module tb_des_out_fifo;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic [63:0]   i_ciphertext = '0;
    logic          i_dv = 1'b0;
    logic [31:0]   o_data;
    logic          o_valid;
    logic          i_ready = 1'b0;
    logic [CW-1:0] o_count;
    logic          o_almost_full;
    logic          o_overflow;
    logic          i_clr_overflow = 1'b0;

    int checks = 0;
    int passes = 0;
    logic [31:0] exp_q[$];

    des_out_fifo #(.DEPTH(DEPTH), .AFULL_MARGIN(17)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ciphertext(i_ciphertext), .i_dv(i_dv),
        .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_count(o_count),
        .o_almost_full(o_almost_full), .o_overflow(o_overflow),
        .i_clr_overflow(i_clr_overflow)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: a word is transferred at the next rising edge whenever valid && ready.
    always @(negedge i_clk) begin
        if (i_rst_n && o_valid && i_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL stream_unexpected: got %0h expected no word", o_data);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (o_data === e) passes++;
                else $display("FAIL stream_word: got %0h expected %0h", o_data, e);
            end
        end
    end

    // Called at posedge+1; presents one block for exactly one edge.
    task automatic push(input logic [63:0] d, input bit expect_out);
        i_dv = 1'b1;
        i_ciphertext = d;
        if (expect_out) begin
            exp_q.push_back(d[63:32]);
            exp_q.push_back(d[31:0]);
        end
        @(posedge i_clk); #1;
        i_dv = 1'b0;
    endtask

    function automatic logic [63:0] pat(input int i);
        return {8'hA0, 24'(i), 8'h50, 24'(i * 3 + 7)};
    endfunction

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || o_valid) && n < budget) begin
            @(posedge i_clk); #1;
            n++;
        end
        checks++;
        if (n < budget) passes++;
        else $display("FAIL %s: timeout with %0d words pending, expected 0", name, exp_q.size());
    endtask

    initial begin
        // Reset and empty
        repeat (3) @(posedge i_clk);
        @(negedge i_clk) i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        check("reset_valid", 64'(o_valid), 64'd0);
        check("reset_count", 64'(o_count), 64'd0);
        check("reset_overflow", 64'(o_overflow), 64'd0);
        check("reset_afull", 64'(o_almost_full), 64'd1);
        check("reset_data", 64'(o_data), 64'd0);

        // Single block, one-cycle latency, high then low
        i_ready = 1'b1;
        push(64'h958313539316391d, 1'b1);
        check("single_latency_valid", 64'(o_valid), 64'd1);
        check("single_first_word", 64'(o_data), 64'h95831353);
        repeat (2) @(posedge i_clk); #1;
        check("single_done_valid", 64'(o_valid), 64'd0);
        check("single_done_count", 64'(o_count), 64'd0);

        // Back-to-back burst of DEPTH blocks with consumer stalled
        i_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) push(pat(i), 1'b1);
        check("burst_count", 64'(o_count), 64'd16);
        check("burst_overflow", 64'(o_overflow), 64'd0);
        check("burst_afull", 64'(o_almost_full), 64'd1);
        i_ready = 1'b1;
        wait_drain("burst_drain", 80);
        check("burst_drained_count", 64'(o_count), 64'd0);

        // Overflow: 17th block dropped, set beats clear, then clear works
        i_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) push(pat(100 + i), 1'b1);
        push(64'hdeadbeefcafef00d, 1'b0);
        check("ovf_flag", 64'(o_overflow), 64'd1);
        check("ovf_count", 64'(o_count), 64'd16);
        i_clr_overflow = 1'b1;
        push(64'hdeadbeefcafef00d, 1'b0);
        check("ovf_set_beats_clear", 64'(o_overflow), 64'd1);
        @(posedge i_clk); #1;
        i_clr_overflow = 1'b0;
        check("ovf_cleared", 64'(o_overflow), 64'd0);
        i_ready = 1'b1;
        wait_drain("ovf_drain", 80);

        // Full with a push landing on the pop of the head's low word
        i_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) push(pat(200 + i), 1'b1);
        i_ready = 1'b1;
        @(posedge i_clk); #1;          // high word of head leaves
        push(64'h1, 1'b1);             // coincides with low word leaving
        i_ready = 1'b0;
        check("fullpp_count", 64'(o_count), 64'd16);
        check("fullpp_overflow", 64'(o_overflow), 64'd0);
        // Stall toggling mid-stream must not skip or repeat a word
        for (int i = 0; i < 6; i++) begin
            i_ready = ~i_ready;
            @(posedge i_clk); #1;
        end
        i_ready = 1'b1;
        wait_drain("fullpp_drain", 100);

        // Async reset after the high word of a block has gone out
        i_ready = 1'b0;
        push(64'h0123456789abcdef, 1'b1);
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        i_rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("rst_mid_valid", 64'(o_valid), 64'd0);
        check("rst_mid_count", 64'(o_count), 64'd0);
        check("rst_mid_data", 64'(o_data), 64'd0);
        #2 i_rst_n = 1'b1;
        i_ready = 1'b1;
        repeat (4) @(posedge i_clk); #1;
        check("rst_after_valid", 64'(o_valid), 64'd0);
        check("rst_after_count", 64'(o_count), 64'd0);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/des_out_fifo.md
Name: des_out_fifo

Overview:
Output buffer that sits directly downstream of the pipelined DES core. The core accepts one block per cycle and cannot be stalled, so this block captures every 64-bit result flagged by the core's o_dv into a FIFO. It then drains each result as two 32-bit words over a valid/ready stream toward the Caravel-side bus logic. It also gives the upstream issuer an almost-full indication and a sticky overflow flag.

Parameters:
DEPTH, 16, number of 64-bit entries (power of two, >=4)
AFULL_MARGIN, 17, o_almost_full asserts when free entries <= AFULL_MARGIN (covers 16-stage core latency + 1)
CW, $clog2(DEPTH)+1, width of occupancy count

Ports:
i_clk  in  1  clock; all state on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_ciphertext  in  64  result from DES core (o_ciphertext)
i_dv  in  1  result valid from DES core (o_dv); one push per cycle when high
o_data  out  32  stream word; high half [63:32] first, then low half [31:0]
o_valid  out  1  o_data valid
i_ready  in  1  consumer ready; transfer when o_valid && i_ready
o_count  out  CW  entries currently held (0..DEPTH)
o_almost_full  out  1  (DEPTH - o_count) <= AFULL_MARGIN
o_overflow  out  1  sticky: a push arrived while full and was dropped
i_clr_overflow  in  1  synchronous clear of o_overflow

Behaviour:
- Reset (i_rst_n low, async): wr_ptr=0, rd_ptr=0, count=0, half=0, o_valid=0, o_overflow=0, o_data=0. o_almost_full follows count, so it is 1 when AFULL_MARGIN>=DEPTH. Storage array is not reset. Reset mid-drain discards all entries and any partially sent block.
- Storage: DEPTH x 64 register array; pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Push: on a rising edge with i_dv=1 and (count<DEPTH or pop_now), write i_ciphertext at wr_ptr and increment wr_ptr. If full and not pop_now, drop the data and set o_overflow=1.
- Read side: o_valid = (count != 0), combinational from registered count. o_data = half ? mem[rd_ptr][31:0] : mem[rd_ptr][63:32], combinational mux of registered state.
- xfer = o_valid && i_ready. On xfer with half=0, set half=1. On xfer with half=1, set half=0 and pop (pop_now=1, rd_ptr+1).
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Full + simultaneous push and pop of the final half: the push is accepted, no overflow, and count stays DEPTH.
- Empty + push: the entry becomes visible on o_valid in the next cycle. There is no fall-through; minimum latency from i_dv to first word is 1 cycle.
- i_ready toggling mid-block: half is held; the low word is never skipped or repeated.
- o_overflow: set has priority over i_clr_overflow in the same cycle; otherwise the clear takes effect on the next edge.
- Words per block are always exactly 2, high then low. Byte order within a word is unchanged.
- No combinational path from i_dv or i_ciphertext to any output.

Test Plan:
- Reset and empty: after i_rst_n deasserts, o_valid=0, o_count=0, o_overflow=0. With DEPTH=16 and AFULL_MARGIN=17, o_almost_full=1.
- Single block: push 64'h958313539316391d with i_ready=1. Next cycle o_data=32'h95831353, following cycle 32'h9316391d, then o_valid=0 and o_count=0.
- Back-to-back burst: push 16 consecutive blocks (i_dv high 16 cycles) with i_ready=0. Result: o_count=16, o_overflow=0. Then hold i_ready=1 and expect 32 words in push order, high/low alternating, with correct pointer wrap.
- Overflow: fill 16 entries with i_ready=0, then push a 17th block 64'hdeadbeefcafef00d. Result: o_overflow=1, o_count=16, and the dropped value never appears on o_data. Pulse i_clr_overflow to return o_overflow to 0.
- Full with simultaneous push/pop: with the FIFO full and the low half of the head being transferred, push 64'h1. Result: no overflow, o_count stays 16, and 64'h1 is emitted last.
- Async reset mid-drain: after the high word of a block is transferred, drop i_rst_n for 3ns between edges. Outputs clear immediately, and after release o_valid=0 and the low word is never emitted.
